// File: rtl/sort_net_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_net_n_pkg
// Description : Shared constants and helpers for the order-statistic blocks.
//               Sets the legal range of vector sizes and derives the rank
//               port width from a vector size.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_net_n_pkg;

  localparam int MIN_INPUTS = 2;
  localparam int MAX_INPUTS = 16;

  // Width of a rank index able to address every slot of an n-sample vector.
  function automatic int rank_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_net_n_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_net_n_if
// Description : Input/output handshake bundle of the sorting network.
//               Ports (all signals):
//                 din           packed samples, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//                 din_rank      requested order statistic (0 = min)
//                 din_valid     din/din_rank valid
//                 din_ready     sorter accepts a vector this cycle
//                 dout_sorted   ascending vector, slot 0 = min
//                 dout_sel      selected order statistic
//                 dout_rank_err requested rank was out of range and clamped
//                 dout_valid    outputs valid
//                 dout_ready    downstream accepts outputs
//               master = producer/consumer side, slave = sorter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_net_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 9
);
  import sort_net_n_pkg::*;

  localparam int RANK_W = rank_width(NUM_INPUTS);

  logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
  logic [RANK_W-1:0]                din_rank;
  logic                             din_valid;
  logic                             din_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] dout_sorted;
  logic [DATA_WIDTH-1:0]            dout_sel;
  logic                             dout_rank_err;
  logic                             dout_valid;
  logic                             dout_ready;

  modport master (
    output din, din_rank, din_valid, dout_ready,
    input  din_ready, dout_sorted, dout_sel, dout_rank_err, dout_valid
  );

  modport slave (
    input  din, din_rank, din_valid, dout_ready,
    output din_ready, dout_sorted, dout_sel, dout_rank_err, dout_valid
  );

endinterface
`default_nettype wire

// File: rtl/sort_net_n_cmp_swap.sv
`default_nettype none
// ============================================================================
// Module      : sort_net_n_cmp_swap
// Description : Combinational unsigned compare-exchange.
//               Ports: a, b (inputs, a = lower slot), lo = min(a,b), hi = max(a,b).
//               Equal inputs pass through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_net_n_cmp_swap
  import sort_net_n_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  logic swap;

  // Strict compare so ties never swap.
  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/sort_net_n.sv
`default_nettype none
// ============================================================================
// Module      : sort_net_n
// Description : Pipelined NUM_INPUTS-sample odd-even transposition sorter with
//               valid/ready handshake, full sorted output and a per-vector
//               selectable order statistic.
//               Ports: clk, arst (async active-high), bus (sort_net_n_if.slave).
// Revision    : 1.0 - initial release
// ============================================================================
module sort_net_n
  import sort_net_n_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 9
) (
  input  logic        clk,
  input  logic        arst,
  sort_net_n_if.slave bus
);

  localparam int                RANK_W     = rank_width(NUM_INPUTS);
  localparam logic [RANK_W:0]   c_num_ext  = (RANK_W + 1)'(NUM_INPUTS);
  localparam logic [RANK_W-1:0] c_rank_max = RANK_W'(NUM_INPUTS - 1);

  typedef logic [DATA_WIDTH-1:0] sample_t;

  if (NUM_INPUTS < MIN_INPUTS || NUM_INPUTS > MAX_INPUTS) begin : g_bad_num_inputs
    $error("sort_net_n: NUM_INPUTS must be in 2..16");
  end

  // [stage][slot]
  sample_t data_q   [NUM_INPUTS][NUM_INPUTS];
  sample_t data_d   [NUM_INPUTS][NUM_INPUTS];
  sample_t stage_in [NUM_INPUTS][NUM_INPUTS];

  logic [NUM_INPUTS-1:0] valid_q, valid_d;
  logic [NUM_INPUTS-1:0] err_q,   err_d;
  logic [RANK_W-1:0]     rank_q [NUM_INPUTS];
  logic [RANK_W-1:0]     rank_d [NUM_INPUTS];

  logic stall;
  logic rank_oob;

  // Stage 0 sorts the incoming vector; every later stage sorts its predecessor.
  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      stage_in[0][k] = bus.din[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int s = 1; s < NUM_INPUTS; s++) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        stage_in[s][k] = data_q[s-1][k];
      end
    end
  end

  // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..
  // A slot that heads a pair owns the compare-exchange; the slot above it is
  // driven by that instance; an unpaired edge slot passes straight through.
  for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_stage
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_slot
      if ((k % 2) == (s % 2) && (k + 1) < NUM_INPUTS) begin : g_cx
        sort_net_n_cmp_swap #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_cmp_swap (
          .a  (stage_in[s][k]),
          .b  (stage_in[s][k+1]),
          .lo (data_d[s][k]),
          .hi (data_d[s][k+1])
        );
      end else if ((k % 2) == (s % 2) || k == 0) begin : g_pass
        assign data_d[s][k] = stage_in[s][k];
      end
    end
  end

  // Sideband shift chain: valid, clamped rank and clamp flag travel with data.
  always_comb begin
    stall    = valid_q[NUM_INPUTS-1] && !bus.dout_ready;
    rank_oob = ({1'b0, bus.din_rank} >= c_num_ext);

    valid_d    = '0;
    err_d      = '0;
    valid_d[0] = bus.din_valid;
    err_d[0]   = bus.din_valid && rank_oob;
    rank_d[0]  = rank_oob ? c_rank_max : bus.din_rank;
    for (int s = 1; s < NUM_INPUTS; s++) begin
      valid_d[s] = valid_q[s-1];
      err_d[s]   = err_q[s-1];
      rank_d[s]  = rank_q[s-1];
    end
  end

  // One global enable: a stall freezes every stage so nothing is lost.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < NUM_INPUTS; s++) begin
        rank_q[s] <= '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
          data_q[s][k] <= '0;
        end
      end
    end else if (!stall) begin
      valid_q <= valid_d;
      err_q   <= err_d;
      rank_q  <= rank_d;
      data_q  <= data_d;
    end
  end

  assign bus.din_ready     = !stall;
  assign bus.dout_valid    = valid_q[NUM_INPUTS-1];
  assign bus.dout_rank_err = err_q[NUM_INPUTS-1];
  assign bus.dout_sel      = data_q[NUM_INPUTS-1][rank_q[NUM_INPUTS-1]];

  always_comb begin
    bus.dout_sorted = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      bus.dout_sorted[k*DATA_WIDTH +: DATA_WIDTH] = data_q[NUM_INPUTS-1][k];
    end
  end

endmodule
`default_nettype wire
